// File: rtl/router_egress_arb.sv
// Egress merge stage: four per-lane FIFOs drained onto one valid/ready stream
// by a round-robin arbiter that tags each word with its source lane.
module router_egress_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] din1,
   input  logic [DATA_WIDTH-1:0] din2,
   input  logic [DATA_WIDTH-1:0] din3,
   input  logic [3:0]            din_vld,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic [1:0]            dout_port,
   input  logic                  dout_ready,
   output logic [3:0]            drop,
   output logic [3:0]            full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] din_lane [4];
   logic [DATA_WIDTH-1:0] head     [4];
   logic [3:0]            nonempty;
   logic [3:0]            push;
   logic [3:0]            pop;

   logic [DATA_WIDTH-1:0] dout_reg;
   logic [1:0]            dout_port_reg;
   logic                  dout_valid_reg;
   logic [1:0]            rr_ptr_reg;

   logic                  out_free;
   logic                  grant_any;
   logic [1:0]            grant_idx;
   logic [1:0]            scan_idx;

   assign din_lane[0] = din0;
   assign din_lane[1] = din1;
   assign din_lane[2] = din2;
   assign din_lane[3] = din3;

   // The output register may take a new word when empty or being consumed now.
   assign out_free = ~dout_valid_reg | dout_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_port
         logic [DATA_WIDTH-1:0] mem [DEPTH];
         logic [AW-1:0]         wr_ptr_reg;
         logic [AW-1:0]         rd_ptr_reg;
         logic [CW-1:0]         count_reg;
         logic                  drop_reg;

         assign full[gi]     = (count_reg == CW'(DEPTH));
         assign nonempty[gi] = (count_reg != '0);
         // Fullness is judged before the edge, so a same-edge pop never rescues a push.
         assign push[gi]     = din_vld[gi] & ~full[gi];
         assign pop[gi]      = out_free & grant_any & (grant_idx == 2'(gi));
         assign head[gi]     = mem[rd_ptr_reg];
         assign drop[gi]     = drop_reg;

         always_ff @(posedge clk) begin
            if (push[gi]) begin
               mem[wr_ptr_reg] <= din_lane[gi];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
               drop_reg   <= 1'b0;
            end else begin
               if (push[gi]) begin
                  wr_ptr_reg <= wr_ptr_reg + AW'(1);
               end
               if (pop[gi]) begin
                  rd_ptr_reg <= rd_ptr_reg + AW'(1);
               end
               count_reg <= count_reg + CW'(push[gi]) - CW'(pop[gi]);
               if (din_vld[gi] && full[gi]) begin
                  drop_reg <= 1'b1;
               end
            end
         end
      end
   endgenerate

   // First non-empty FIFO at or after rr_ptr, wrapping modulo 4.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = rr_ptr_reg;
      scan_idx  = rr_ptr_reg;
      for (int k = 0; k < 4; k++) begin
         scan_idx = rr_ptr_reg + 2'(k);
         if (!grant_any && nonempty[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout_reg       <= '0;
         dout_port_reg  <= '0;
         dout_valid_reg <= 1'b0;
         rr_ptr_reg     <= '0;
      end else if (out_free) begin
         if (grant_any) begin
            dout_reg       <= head[grant_idx];
            dout_port_reg  <= grant_idx;
            dout_valid_reg <= 1'b1;
            rr_ptr_reg     <= grant_idx + 2'd1;
         end else begin
            dout_valid_reg <= 1'b0;
         end
      end
   end

   assign dout       = dout_reg;
   assign dout_port  = dout_port_reg;
   assign dout_valid = dout_valid_reg;

endmodule

// File: tb/tb_router_egress_arb.sv
// Bench for router_egress_arb: directed vector table for the corner cases,
// then randomized traffic against a queue-based reference model.
module tb_router_egress_arb;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] din0, din1, din2, din3;
   logic [3:0]    din_vld;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic [1:0]    dout_port;
   logic          dout_ready;
   logic [3:0]    drop;
   logic [3:0]    full;

   always #5 clk = ~clk;

   router_egress_arb #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .din0(din0), .din1(din1), .din2(din2), .din3(din3),
      .din_vld(din_vld),
      .dout(dout), .dout_valid(dout_valid), .dout_port(dout_port),
      .dout_ready(dout_ready),
      .drop(drop), .full(full)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One row: inputs before an edge, outputs expected just after it.
   typedef struct {
      bit        rst;
      bit [3:0]  vld;
      bit [31:0] d0, d1, d2, d3;
      bit        rdy;
      bit        ev;
      bit        cd;
      bit [1:0]  ep;
      bit [31:0] ed;
      bit [3:0]  edrop;
      bit [3:0]  efull;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rst, bit [3:0] vld, bit [31:0] d0, bit [31:0] d1,
                               bit [31:0] d2, bit [31:0] d3, bit rdy, bit ev, bit cd,
                               bit [1:0] ep, bit [31:0] ed, bit [3:0] edrop, bit [3:0] efull);
      vec_t v;
      v.rst = rst; v.vld = vld; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
      v.rdy = rdy; v.ev = ev; v.cd = cd; v.ep = ep; v.ed = ed;
      v.edrop = edrop; v.efull = efull;
      vecs.push_back(v);
   endfunction

   function automatic void add_reset(bit rdy);
      add(1, 0, 0, 0, 0, 0, rdy, 0, 1, 0, 0, 0, 0);
   endfunction

   function automatic void build_vectors();
      // Single word on lane 2
      add_reset(1); add_reset(1);
      add(0, 4'b0100, 0, 0, 32'hA5A5_0002, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 32'hA5A5_0002, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      // Round-robin fairness
      add_reset(1);
      add(0, 4'hF, 32'h10, 32'h11, 32'h12, 32'h13, 1, 0, 0, 0, 0, 0, 0);
      add(0, 4'hF, 32'h10, 32'h11, 32'h12, 32'h13, 1, 1, 1, 0, 32'h10, 0, 0);
      for (int p = 1; p < 4; p++) add(0, 0, 0, 0, 0, 0, 1, 1, 1, 2'(p), 32'h10 + p, 0, 0);
      for (int p = 0; p < 4; p++) add(0, 0, 0, 0, 0, 0, 1, 1, 1, 2'(p), 32'h10 + p, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      // Backpressure hold on port 1, second word queued behind it
      add(0, 4'b0010, 0, 32'hB0B0_0001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 4'b0010, 0, 32'hB0B0_0002, 0, 0, 0, 1, 1, 1, 32'hB0B0_0001, 0, 0);
      for (int c = 0; c < 5; c++) add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'hB0B0_0001, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'hB0B0_0002, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      // Overflow of FIFO 3 while output is stalled
      add_reset(0);
      add(0, 4'b1000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 4'b1000, 0, 0, 0, 2, 0, 1, 1, 3, 1, 0, 0);
      add(0, 4'b1000, 0, 0, 0, 3, 0, 1, 1, 3, 1, 0, 0);
      add(0, 4'b1000, 0, 0, 0, 4, 0, 1, 1, 3, 1, 0, 0);
      add(0, 4'b1000, 0, 0, 0, 5, 0, 1, 1, 3, 1, 0, 4'b1000);
      add(0, 4'b1000, 0, 0, 0, 6, 0, 1, 1, 3, 1, 4'b1000, 4'b1000);
      for (int v = 2; v <= 5; v++) add(0, 0, 0, 0, 0, 0, 1, 1, 1, 3, v, 4'b1000, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1000, 0);
      // Full FIFO 0 pushed on the same edge it pops
      add_reset(0);
      add(0, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 4'b0001, 2, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
      add(0, 4'b0001, 3, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
      add(0, 4'b0001, 4, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
      add(0, 4'b0001, 5, 0, 0, 0, 0, 1, 1, 0, 1, 0, 4'b0001);
      add(0, 4'b0001, 6, 0, 0, 0, 1, 1, 1, 0, 2, 4'b0001, 0);
      for (int v = 3; v <= 5; v++) add(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, v, 4'b0001, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0001, 0);
      // Reset during an in-flight handshake
      add_reset(0);
      add(0, 4'b0110, 0, 32'h21, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 4'b0110, 0, 32'h23, 32'h24, 0, 0, 1, 1, 1, 32'h21, 0, 0);
      add_reset(1);
      add(0, 4'b1010, 0, 32'h31, 0, 32'h33, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h31, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 32'h33, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
   endfunction

   // Reference model: one queue per port plus the output register contents.
   logic [31:0] q [4][$];
   bit          m_valid;
   bit [1:0]    m_port;
   bit [31:0]   m_data;
   int          m_rr;
   bit [3:0]    m_drop;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) q[i].delete();
      m_valid = 0; m_port = 0; m_data = 0; m_rr = 0; m_drop = 0;
   endtask

   task automatic model_step(input bit rst, input bit [3:0] vld, input bit [31:0] d [4], input bit rdy);
      int  sz [4];
      bit  found;
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 4; i++) sz[i] = q[i].size();
      if (!m_valid || rdy) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            int p;
            p = (m_rr + k) % 4;
            if (!found && sz[p] > 0) begin
               found   = 1;
               m_data  = q[p].pop_front();
               m_port  = 2'(p);
               m_valid = 1;
               m_rr    = (p + 1) % 4;
            end
         end
         if (!found) m_valid = 0;
      end
      for (int i = 0; i < 4; i++) begin
         if (vld[i]) begin
            if (sz[i] == DEPTH) m_drop[i] = 1;
            else q[i].push_back(d[i]);
         end
      end
   endtask

   initial begin
      bit [31:0] rd [4];
      bit        rrst;
      bit [3:0]  rvld;
      bit        rrdy;
      int        ready_pct;
      bit [3:0]  exp_full;

      reset = 1; din_vld = 0; dout_ready = 0;
      din0 = 0; din1 = 0; din2 = 0; din3 = 0;

      build_vectors();
      foreach (vecs[i]) begin
         reset = vecs[i].rst; din_vld = vecs[i].vld; dout_ready = vecs[i].rdy;
         din0 = vecs[i].d0; din1 = vecs[i].d1; din2 = vecs[i].d2; din3 = vecs[i].d3;
         @(posedge clk); #1;
         chk($sformatf("vec%0d dout_valid", i), 32'(dout_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d drop", i), 32'(drop), 32'(vecs[i].edrop));
         chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].efull));
         if (vecs[i].cd) begin
            chk($sformatf("vec%0d dout_port", i), 32'(dout_port), 32'(vecs[i].ep));
            chk($sformatf("vec%0d dout", i), dout, vecs[i].ed);
         end
      end

      // Randomized traffic with alternating light/heavy backpressure.
      reset = 1; din_vld = 0; dout_ready = 0;
      @(posedge clk); #1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         ready_pct = ((c / 200) % 2 == 0) ? 85 : 30;
         rrst = ($urandom_range(0, 399) == 0);
         rvld = 4'($urandom);
         rrdy = ($urandom_range(0, 99) < ready_pct);
         for (int i = 0; i < 4; i++) rd[i] = $urandom;
         reset = rrst; din_vld = rvld; dout_ready = rrdy;
         din0 = rd[0]; din1 = rd[1]; din2 = rd[2]; din3 = rd[3];
         @(posedge clk); #1;
         model_step(rrst, rvld, rd, rrdy);
         for (int i = 0; i < 4; i++) exp_full[i] = (q[i].size() == DEPTH);
         chk($sformatf("rnd%0d dout_valid", c), 32'(dout_valid), 32'(m_valid));
         chk($sformatf("rnd%0d dout_port", c), 32'(dout_port), 32'(m_port));
         chk($sformatf("rnd%0d dout", c), dout, m_data);
         chk($sformatf("rnd%0d drop", c), 32'(drop), 32'(m_drop));
         chk($sformatf("rnd%0d full", c), 32'(full), 32'(exp_full));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
